data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Responder end of the execute/mem stage's split data-memory interface.
- Serves the 16-bit half-word read and write beats that the stage issues, two per 32-bit access, from an internal half-word memory.
- Tracks read pairs and reassembles each pair of read beats into a 32-bit word for the writeback path.
- Flags misaligned, out-of-range and conflicting requests.

Parameters:
- DEPTH_HW, 1024, number of 16-bit half-words in the memory; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of half-word 0; must be DEPTH_HW*2-aligned.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- mem_re_i  input  1  read beat request, sampled each cycle.
- mem_we_i  input  1  write beat request, sampled each cycle.
- addr_i  input  32  byte address of the half-word beat.
- wdata_i  input  16  write half-word.
- rdata_o  output  16  read half-word, registered.
- rvalid_o  output  1  rdata_o is valid this cycle (1-cycle pulse per accepted read).
- word_o  output  32  assembled read word {second beat, first beat}.
- word_valid_o  output  1  word_o is valid this cycle (1-cycle pulse).
- err_o  output  1  previous-cycle request was rejected (1-cycle pulse).

Behaviour:
- Reset (rst_ni low, asynchronous): rdata_o=0, rvalid_o=0, word_o=0, word_valid_o=0, err_o=0, FSM=IDLE. Memory contents are not reset.
- Reset asserted mid-pair discards the captured beat. The first read after reset release is a first beat.
- Address decode: offset = addr_i - BASE_ADDR; index = offset[..:1].
- A request is rejected if any of the following holds:
  - addr_i[0]=1 (misaligned);
  - offset >= DEPTH_HW*2 (out of range, unsigned compare);
  - mem_re_i and mem_we_i are both 1 (conflict).
- Rejected request: no memory write; rvalid_o=0; err_o=1 in the next cycle; FSM returns to IDLE, dropping any captured beat.
- Write (accepted, mem_we_i=1): the memory half-word at index is updated at the rising edge of the request cycle. No response pulse.
- Read (accepted, mem_re_i=1): request in cycle N gives rdata_o = mem[index] and rvalid_o=1 in cycle N+1.
- Read-after-write: a write in cycle N followed by a read of the same index in cycle N+1 returns the new data.
- Idle cycle (neither request): rvalid_o=0, err_o=0; memory unchanged.
- Pair FSM states are IDLE and HALF.
  - IDLE: an accepted read captures the beat as the low half at N+1 and moves to HALF. Anything else stays in IDLE.
  - HALF, accepted read in cycle N+1: at N+2, word_o = {mem[index], low}, word_valid_o=1 (coincident with rvalid_o), next state IDLE.
  - HALF, write, idle cycle or rejected request: drop the captured beat and move to IDLE; word_valid_o stays 0.
- Pair beats therefore must be back-to-back cycles, matching the initiator's stall of one cycle.
- The pair logic does not check that the two beat addresses are consecutive; it assembles in arrival order.
- word_o holds its last value between pulses.
- rdata_o holds its last value while rvalid_o=0.

Decomposition:
- Shared package dmem_pkg holds:
  - enum pair_state_t {IDLE, HALF};
  - HW_BYTES=2;
  - function in_range(addr, base, depth).
- One sub-module, hw_sram: a single-port DEPTH_HW x 16 array with a write enable and a registered read port. This lets a technology macro replace it.
- data_mem_resp keeps decode, error, pair FSM and word assembly.

Test Plan:
1. Write 0x1234 at 0x10, then 0xABCD at 0x12; read pair 0x10, 0x12 on back-to-back cycles -> rvalid_o pulses at N+1 and N+2 with 0x1234 then 0xABCD; word_valid_o at N+2 with word_o=0xABCD1234.
2. Single read at 0x10 followed by an idle cycle, then a read pair at 0x20/0x22 holding 0x5555/0x6666 -> no word_valid_o for the lone beat; the later pair gives word_o=0x66665555.
3. Read at 0x11 (misaligned) -> err_o=1 next cycle, rvalid_o=0. Write at BASE+DEPTH_HW*2 -> err_o=1, and a readback of index 0 is unchanged.
4. mem_re_i=mem_we_i=1 at 0x10 with wdata 0xFFFF -> err_o=1; a later read of 0x10 still returns 0x1234.
5. Write 0x0F0F at 0x30 in cycle N, read 0x30 in cycle N+1 -> rdata_o=0x0F0F at N+2.
6. rst_ni pulsed low asynchronously while the FSM is in HALF -> all outputs 0 immediately. After release, a read pair at 0x10/0x12 gives word_o=0xABCD1234 with no stale beat.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// The responder serves 16-bit beats and pairs two read beats into one 32-bit word.
package dmem_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned HW_BYTES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } pair_state_t;

  // Widened to 33 bits so that depth*2 cannot overflow the compare.
  // Addresses below base wrap to large offsets and are rejected.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int unsigned       depth);
    logic [ADDR_W:0] offset;
    offset = {1'b0, addr - base};
    return offset < (33'(depth) * 33'(HW_BYTES));
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Split data-memory bus between the execute/mem stage and the responder.
interface data_mem_resp_if;
  import dmem_pkg::*;

  logic              mem_re_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              err_o;

  modport slave (
    input  mem_re_i, mem_we_i, addr_i, wdata_i,
    output rdata_o, rvalid_o, word_o, word_valid_o, err_o
  );

  modport master (
    output mem_re_i, mem_we_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o, word_o, word_valid_o, err_o
  );

endinterface

// File: rtl/data_mem_resp_hw_sram.sv
// Single-port half-word array with a registered read port; a technology macro can replace it.
module hw_sram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     re,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Responder for the stage's half-word data bus: decode, reject, serve beats and pair reads.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_HW  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_HW);

  logic             aligned;
  logic             addr_ok;
  logic             reject;
  logic             rd_ok;
  logic             wr_ok;
  logic [IDX_W-1:0] index;
  logic [DATA_W-1:0] rdata;

  pair_state_t      state_q, state_d;
  logic             word_fire;

  logic             rvalid_q;
  logic             err_q;
  logic             word_valid_q;
  logic [DATA_W-1:0] low_q;
  logic [WORD_W-1:0] word_hold_q;

  // BASE_ADDR is aligned to the array size, so the index bits of the raw address equal those of the offset.
  always_comb begin
    aligned = ~bus.addr_i[0];
    addr_ok = in_range(bus.addr_i, BASE_ADDR, DEPTH_HW);
    reject  = (bus.mem_re_i | bus.mem_we_i) &
              ~(aligned & addr_ok & ~(bus.mem_re_i & bus.mem_we_i));
    rd_ok   = bus.mem_re_i & ~reject;
    wr_ok   = bus.mem_we_i & ~reject;
    index   = bus.addr_i[IDX_W:1];
  end

  hw_sram #(
    .DEPTH (DEPTH_HW)
  ) u_sram (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .re    (rd_ok),
    .we    (wr_ok),
    .addr  (index),
    .wdata (bus.wdata_i),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // In HALF the first beat is on the SRAM output, so a second accepted read latches it as the low half.
  always_comb begin
    state_d   = state_q;
    word_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_ok) begin
          state_d = HALF;
        end
      end
      HALF: begin
        state_d   = IDLE;
        word_fire = rd_ok;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      word_valid_q <= 1'b0;
      low_q        <= '0;
      word_hold_q  <= '0;
    end else begin
      rvalid_q     <= rd_ok;
      err_q        <= reject;
      word_valid_q <= word_fire;
      if (word_fire) begin
        low_q <= rdata;
      end
      if (word_valid_q) begin
        word_hold_q <= {rdata, low_q};
      end
    end
  end

  assign bus.rdata_o      = rdata;
  assign bus.rvalid_o     = rvalid_q;
  assign bus.err_o        = err_q;
  assign bus.word_valid_o = word_valid_q;
  assign bus.word_o       = word_valid_q ? {rdata, low_q} : word_hold_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed plus randomized checks of data_mem_resp against a beat-level reference model.
module tb_data_mem_resp;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_resp_if bus ();

  data_mem_resp #(
    .DEPTH_HW  (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_mem [DEPTH];
  int          run_len;
  logic [15:0] prev_beat;
  logic [15:0] exp_rdata;
  logic [31:0] exp_word;
  logic        exp_rvalid;
  logic        exp_wvalid;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".rvalid"},     32'(bus.rvalid_o),     32'(exp_rvalid));
    check({tag, ".err"},        32'(bus.err_o),        32'(exp_err));
    check({tag, ".word_valid"}, 32'(bus.word_valid_o), 32'(exp_wvalid));
    check({tag, ".rdata"},      32'(bus.rdata_o),      32'(exp_rdata));
    check({tag, ".word"},       bus.word_o,            exp_word);
  endtask

  // Model: accepted reads in consecutive cycles form pairs; every second beat of a run completes a word.
  task automatic applyStimulus(input string tag, input logic re, input logic we,
                               input logic [31:0] addr, input logic [15:0] wdata);
    logic [31:0] off;
    logic        valid_req;
    int          idx;
    off        = addr - BASE;
    valid_req  = (addr[0] == 1'b0) && (off < DEPTH * 2) && !(re && we);
    idx        = int'(off >> 1);
    exp_rvalid = re && valid_req;
    exp_err    = (re || we) && !valid_req;
    exp_wvalid = 1'b0;
    if (exp_rvalid) begin
      exp_rdata = model_mem[idx];
      run_len++;
      if (run_len % 2 == 0) begin
        exp_wvalid = 1'b1;
        exp_word   = {model_mem[idx], prev_beat};
      end
      prev_beat = model_mem[idx];
    end else begin
      run_len = 0;
    end
    if (we && valid_req) model_mem[idx] = wdata;

    bus.mem_re_i = re;
    bus.mem_we_i = we;
    bus.addr_i   = addr;
    bus.wdata_i  = wdata;
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic model_reset();
    run_len   = 0;
    prev_beat = '0;
    exp_rdata = '0;
    exp_word  = '0;
    exp_rvalid = 1'b0;
    exp_wvalid = 1'b0;
    exp_err    = 1'b0;
  endtask

  initial begin
    logic [31:0] raddr;
    int          op;
    bus.mem_re_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.addr_i   = '0;
    bus.wdata_i  = '0;
    model_reset();

    #3;
    checkOutput("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      applyStimulus("fill", 1'b0, 1'b1, BASE + 32'(2 * i), 16'($urandom));
    end

    applyStimulus("t1.w0",  1'b0, 1'b1, BASE + 32'h10, 16'h1234);
    applyStimulus("t1.w1",  1'b0, 1'b1, BASE + 32'h12, 16'hABCD);
    applyStimulus("t1.r0",  1'b1, 1'b0, BASE + 32'h10, 16'h0);
    applyStimulus("t1.r1",  1'b1, 1'b0, BASE + 32'h12, 16'h0);
    check("t1.word_const", bus.word_o, 32'hABCD1234);
    applyStimulus("t1.idle", 1'b0, 1'b0, BASE, 16'h0);

    applyStimulus("t2.w0",  1'b0, 1'b1, BASE + 32'h20, 16'h5555);
    applyStimulus("t2.w1",  1'b0, 1'b1, BASE + 32'h22, 16'h6666);
    applyStimulus("t2.lone", 1'b1, 1'b0, BASE + 32'h10, 16'h0);
    applyStimulus("t2.idle", 1'b0, 1'b0, BASE, 16'h0);
    applyStimulus("t2.r0",  1'b1, 1'b0, BASE + 32'h20, 16'h0);
    applyStimulus("t2.r1",  1'b1, 1'b0, BASE + 32'h22, 16'h0);
    check("t2.word_const", bus.word_o, 32'h66665555);

    applyStimulus("t3.mis",  1'b1, 1'b0, BASE + 32'h11, 16'h0);
    applyStimulus("t3.oor",  1'b0, 1'b1, BASE + 32'(DEPTH * 2), 16'hDEAD);
    applyStimulus("t3.rd0",  1'b1, 1'b0, BASE, 16'h0);
    applyStimulus("t3.low",  1'b0, 1'b1, BASE - 32'd2, 16'hBEEF);

    applyStimulus("t4.both", 1'b1, 1'b1, BASE + 32'h10, 16'hFFFF);
    applyStimulus("t4.idle", 1'b0, 1'b0, BASE, 16'h0);
    applyStimulus("t4.rd",   1'b1, 1'b0, BASE + 32'h10, 16'h0);
    check("t4.rdata_const", 32'(bus.rdata_o), 32'h1234);

    applyStimulus("t5.w",   1'b0, 1'b1, BASE + 32'h30, 16'h0F0F);
    applyStimulus("t5.r",   1'b1, 1'b0, BASE + 32'h30, 16'h0);
    applyStimulus("t5.idle", 1'b0, 1'b0, BASE, 16'h0);

    // Leave the pair FSM holding a first beat, then reset between clock edges.
    applyStimulus("t6.r0", 1'b1, 1'b0, BASE + 32'h20, 16'h0);
    bus.mem_re_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("t6.async");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t6.r1", 1'b1, 1'b0, BASE + 32'h10, 16'h0);
    applyStimulus("t6.r2", 1'b1, 1'b0, BASE + 32'h12, 16'h0);
    check("t6.word_const", bus.word_o, 32'hABCD1234);

    for (int i = 0; i < 400; i++) begin
      raddr = BASE + 32'($urandom_range(0, DEPTH * 2 + 31));
      if ($urandom_range(0, 15) == 0) raddr = BASE - 32'(2 * $urandom_range(1, 4));
      op = int'($urandom_range(0, 9));
      if (op <= 4)      applyStimulus("rnd.rd",   1'b1, 1'b0, raddr, 16'($urandom));
      else if (op <= 7) applyStimulus("rnd.wr",   1'b0, 1'b1, raddr, 16'($urandom));
      else if (op == 8) applyStimulus("rnd.both", 1'b1, 1'b1, raddr, 16'($urandom));
      else              applyStimulus("rnd.idle", 1'b0, 1'b0, raddr, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
